// File: rtl/inst_issue_queue_pkg.sv
// Shared types for the instruction issue queue: fetched entry layout and default depth.
package inst_issue_queue_pkg;

    typedef logic [31:0] Address_t;
    typedef logic [31:0] Inst_t;
    typedef logic        Bit_t;

    typedef struct packed {
        Address_t pc;
        Inst_t    inst;
        Bit_t     iaddr_err;
        Bit_t     itlb_miss;
        Bit_t     itlb_invalid;
    } IssueEntry_t;

    localparam int ISSUE_QUEUE_DEPTH = 8;

    // Number of valid slots in a fetch pair.
    function automatic logic [1:0] slot_count(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/inst_issue_queue.sv
// Dual-push / dual-pop instruction issue queue feeding decoders A and B.
// Optional same-cycle bypass of an empty queue when ISSUE_QUEUE_BYPASS_EN is defined.
module inst_issue_queue
    import inst_issue_queue_pkg::*;
#(
    parameter int DEPTH = ISSUE_QUEUE_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    stall,
    input  logic [1:0]              push_valid,
    input  IssueEntry_t [1:0]       push_data,
    output logic                    push_ready,
    output logic                    out_valid_a,
    output logic                    out_valid_b,
    output IssueEntry_t             out_data_a,
    output IssueEntry_t             out_data_b,
    input  logic                    issue_a,
    input  logic                    issue_b,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rptr_reg, rptr_next;
    logic [PW-1:0] wptr_reg, wptr_next;
    logic [CW-1:0] count_reg, count_next;
    IssueEntry_t   mem_reg [DEPTH];

    logic [PW-1:0] rptr_inc, wptr_inc;
    logic [1:0]    push_n, pop_req, pop_n, skip_n, wr_n;
    logic [CW-1:0] avail_cnt;
    logic          bypass_act;
    IssueEntry_t   comp0, comp1, wr_data0, wr_data1;
    logic [DEPTH-1:0] we_vec, wsel_vec;

    // Readiness depends on registered occupancy only.
    assign push_ready = (count_reg <= CW'(DEPTH - 2));
    assign count      = count_reg;
    assign rptr_inc   = rptr_reg + PW'(1);
    assign wptr_inc   = wptr_reg + PW'(1);

    always_comb begin
        comp0  = push_valid[0] ? push_data[0] : push_data[1];
        comp1  = push_data[1];
        push_n = push_ready ? slot_count(push_valid) : 2'd0;

        if (stall || !issue_a) begin
            pop_req = 2'd0;
        end else if (issue_b) begin
            pop_req = 2'd2;
        end else begin
            pop_req = 2'd1;
        end

`ifdef ISSUE_QUEUE_BYPASS_EN
        bypass_act = (count_reg == '0) && !flush;
`else
        bypass_act = 1'b0;
`endif

        // Retire only what is visible: stored entries, or bypassed pushes when empty.
        avail_cnt = bypass_act ? CW'(push_n) : count_reg;
        pop_n     = (CW'(pop_req) > avail_cnt) ? avail_cnt[1:0] : pop_req;
        skip_n    = bypass_act ? pop_n : 2'd0;
        wr_n      = push_n - skip_n;
        wr_data0  = (skip_n == 2'd1) ? comp1 : comp0;
        wr_data1  = comp1;

        rptr_next  = rptr_reg + PW'(pop_n - skip_n);
        wptr_next  = wptr_reg + PW'(wr_n);
        count_next = count_reg + CW'(push_n) - CW'(pop_n);

        if (flush) begin
            rptr_next  = '0;
            wptr_next  = '0;
            count_next = '0;
            wr_n       = 2'd0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr
            assign wsel_vec[gi] = (wr_n == 2'd2) && (wptr_inc == PW'(gi));
            assign we_vec[gi]   = ((wr_n != 2'd0) && (wptr_reg == PW'(gi))) || wsel_vec[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we_vec[i]) begin
                mem_reg[i] <= wsel_vec[i] ? wr_data1 : wr_data0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            rptr_reg  <= rptr_next;
            wptr_reg  <= wptr_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        out_valid_a = (count_reg != '0);
        out_valid_b = (count_reg >= CW'(2));
        out_data_a  = out_valid_a ? mem_reg[rptr_reg] : '0;
        out_data_b  = out_valid_b ? mem_reg[rptr_inc] : '0;
`ifdef ISSUE_QUEUE_BYPASS_EN
        if (bypass_act) begin
            out_valid_a = (push_n != 2'd0);
            out_valid_b = (push_n == 2'd2);
            out_data_a  = out_valid_a ? comp0 : '0;
            out_data_b  = out_valid_b ? comp1 : '0;
        end
`endif
    end

    a_push_protocol: assert property (@(posedge clk) disable iff (rst)
        (push_valid != 2'b00) |-> push_ready)
        else $error("push while push_ready low");

endmodule

// File: tb/tb_inst_issue_queue.sv
// Self-checking bench for inst_issue_queue: directed table, corner sequences, random vs. queue model.
module tb_inst_issue_queue;
    import inst_issue_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int WW    = $bits(IssueEntry_t);
    typedef logic [WW-1:0] word_t;

    logic              clk = 1'b0;
    logic              rst, flush, stall, issue_a, issue_b;
    logic [1:0]        push_valid;
    IssueEntry_t [1:0] push_data;
    logic              push_ready, out_valid_a, out_valid_b;
    IssueEntry_t       out_data_a, out_data_b;
    logic [CW-1:0]     count;

    int errors = 0;
    int checks = 0;
    int unsigned pc_seq = 32'h0001_0000;
    IssueEntry_t mq[$];

    inst_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .out_valid_a(out_valid_a), .out_valid_b(out_valid_b),
        .out_data_a(out_data_a), .out_data_b(out_data_b),
        .issue_a(issue_a), .issue_b(issue_b), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl, st;
        logic [1:0]  pv;
        logic [31:0] pc0, pc1;
        logic        ia, ib;
        int          ecnt;
        logic        eva, evb;
        logic [31:0] epca, epcb;
    } vec_t;
    vec_t tbl[10];

    function automatic IssueEntry_t mk(input logic [31:0] pc);
        IssueEntry_t e;
        e.pc           = pc;
        e.inst         = ~pc ^ 32'h5a5a_0000;
        e.iaddr_err    = pc[2];
        e.itlb_miss    = pc[3];
        e.itlb_invalid = pc[4];
        return e;
    endfunction

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush = 0; stall = 0; push_valid = 2'b00; issue_a = 0; issue_b = 0;
        push_data[0] = '0; push_data[1] = '0;
    endtask

    task automatic set_push(input logic [1:0] v);
        push_valid   = v;
        push_data[0] = mk(pc_seq);
        push_data[1] = mk(pc_seq + 4);
        pc_seq += 8;
    endtask

    // Visible entries: two oldest queued ones, or (bypass build) the fetch pair into an empty queue.
    task automatic check_model(input string tag);
        IssueEntry_t vis[$];
        int sz;
        logic rdy;
        sz  = mq.size();
        rdy = (DEPTH - sz) >= 2;
        for (int i = 0; i < 2 && i < sz; i++) vis.push_back(mq[i]);
`ifdef ISSUE_QUEUE_BYPASS_EN
        if (sz == 0 && !flush && rdy)
            for (int s = 0; s < 2; s++) if (push_valid[s]) vis.push_back(push_data[s]);
`endif
        chk({tag, "_count"}, word_t'(count), word_t'(sz));
        chk({tag, "_ready"}, word_t'(push_ready), word_t'(rdy));
        chk({tag, "_va"}, word_t'(out_valid_a), word_t'(vis.size() >= 1));
        chk({tag, "_vb"}, word_t'(out_valid_b), word_t'(vis.size() >= 2));
        chk({tag, "_da"}, word_t'(out_data_a), (vis.size() >= 1) ? word_t'(vis[0]) : '0);
        chk({tag, "_db"}, word_t'(out_data_b), (vis.size() >= 2) ? word_t'(vis[1]) : '0);
    endtask

    task automatic model_step();
        IssueEntry_t pushed[$];
        int sz, req, k;
        sz = mq.size();
        if (flush) begin
            mq.delete();
            return;
        end
        if ((DEPTH - sz) >= 2)
            for (int s = 0; s < 2; s++) if (push_valid[s]) pushed.push_back(push_data[s]);
        req = (stall || !issue_a) ? 0 : (issue_b ? 2 : 1);
`ifdef ISSUE_QUEUE_BYPASS_EN
        if (sz == 0) begin
            mq = pushed;
            k = (req < mq.size()) ? req : mq.size();
            repeat (k) void'(mq.pop_front());
            return;
        end
`endif
        k = (req < sz) ? req : sz;
        repeat (k) void'(mq.pop_front());
        foreach (pushed[i]) mq.push_back(pushed[i]);
    endtask

    task automatic run_cycle(input string tag);
        #3;
        check_model(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 0, 2'b11, 32'h1000, 32'h1004, 0, 0, 2, 1, 1, 32'h1000, 32'h1004};
        tbl[1] = '{0, 0, 2'b01, 32'h1008, 32'h0,    0, 0, 3, 1, 1, 32'h1000, 32'h1004};
        tbl[2] = '{0, 0, 2'b00, 32'h0,    32'h0,    1, 1, 1, 1, 0, 32'h1008, 32'h0};
        tbl[3] = '{0, 0, 2'b00, 32'h0,    32'h0,    1, 1, 0, 0, 0, 32'h0,    32'h0};
        tbl[4] = '{0, 0, 2'b10, 32'h0,    32'h2004, 0, 0, 1, 1, 0, 32'h2004, 32'h0};
        tbl[5] = '{0, 0, 2'b11, 32'h2008, 32'h200c, 0, 0, 3, 1, 1, 32'h2004, 32'h2008};
        tbl[6] = '{0, 0, 2'b11, 32'h2010, 32'h2014, 0, 0, 5, 1, 1, 32'h2004, 32'h2008};
        tbl[7] = '{1, 0, 2'b11, 32'h2018, 32'h201c, 1, 0, 0, 0, 0, 32'h0,    32'h0};
        tbl[8] = '{0, 1, 2'b11, 32'h3000, 32'h3004, 1, 0, 2, 1, 1, 32'h3000, 32'h3004};
        tbl[9] = '{0, 0, 2'b00, 32'h0,    32'h0,    1, 0, 1, 1, 0, 32'h3004, 32'h0};

        rst = 1;
        idle();
        #1;
        chk("reset_count", word_t'(count), '0);
        chk("reset_ready", word_t'(push_ready), word_t'(1));
        chk("reset_va", word_t'(out_valid_a), '0);
        chk("reset_vb", word_t'(out_valid_b), '0);
        chk("reset_da", word_t'(out_data_a), '0);
        chk("reset_db", word_t'(out_data_b), '0);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < 10; i++) begin
            flush = tbl[i].fl; stall = tbl[i].st; push_valid = tbl[i].pv;
            push_data[0] = mk(tbl[i].pc0); push_data[1] = mk(tbl[i].pc1);
            issue_a = tbl[i].ia; issue_b = tbl[i].ib;
            @(posedge clk); #1;
            idle();
            chk($sformatf("vec%0d_count", i), word_t'(count), word_t'(tbl[i].ecnt));
            chk($sformatf("vec%0d_ready", i), word_t'(push_ready), word_t'((DEPTH - tbl[i].ecnt) >= 2));
            chk($sformatf("vec%0d_va", i), word_t'(out_valid_a), word_t'(tbl[i].eva));
            chk($sformatf("vec%0d_vb", i), word_t'(out_valid_b), word_t'(tbl[i].evb));
            chk($sformatf("vec%0d_pca", i), word_t'(out_data_a.pc), word_t'(tbl[i].epca));
            chk($sformatf("vec%0d_pcb", i), word_t'(out_data_b.pc), word_t'(tbl[i].epcb));
        end
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        mq.delete();

        // Fill completely, then a dual pop: readiness stays low in that same cycle.
        for (int k = 0; k < DEPTH / 2; k++) begin
            set_push(2'b11);
            run_cycle("fill_full");
        end
        idle();
        #1;
        chk("full_count", word_t'(count), word_t'(DEPTH));
        chk("full_ready", word_t'(push_ready), '0);
        issue_a = 1; issue_b = 1;
        #1;
        chk("full_pop2_ready", word_t'(push_ready), '0);
        run_cycle("full_pop2");
        idle();
        run_cycle("after_pop2");

        // Fill to DEPTH-1 one entry at a time; single pop reopens push_ready.
        flush = 1;
        run_cycle("flush_a");
        idle();
        for (int k = 0; k < DEPTH - 1; k++) begin
            set_push(2'b01);
            run_cycle("fill_m1");
        end
        idle();
        #1;
        chk("m1_ready", word_t'(push_ready), '0);
        issue_a = 1;
        run_cycle("m1_pop1");
        idle();
        #1;
        chk("m1_ready_after", word_t'(push_ready), word_t'(1));

        // Stream 3*DEPTH entries through with simultaneous push and pop to wrap pointers.
        flush = 1;
        run_cycle("flush_b");
        idle();
        for (int k = 0; k < 3 * DEPTH / 2; k++) begin
            set_push(2'b11);
            issue_a = (k > 0);
            issue_b = (k > 0);
            run_cycle("wrap");
        end
        idle();
        issue_a = 1; issue_b = 1;
        run_cycle("wrap_drain");
        idle();

`ifdef ISSUE_QUEUE_BYPASS_EN
        flush = 1;
        run_cycle("flush_c");
        idle();
        push_valid = 2'b11;
        push_data[0] = mk(32'h4000); push_data[1] = mk(32'h4004);
        issue_a = 1; issue_b = 0;
        #1;
        chk("byp_va", word_t'(out_valid_a), word_t'(1));
        chk("byp_pca", word_t'(out_data_a.pc), word_t'(32'h4000));
        run_cycle("byp");
        idle();
        #1;
        chk("byp_count", word_t'(count), word_t'(1));
        chk("byp_next_pca", word_t'(out_data_a.pc), word_t'(32'h4004));
`endif

        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic busy;
            busy    = ((cyc / 150) % 2) == 1;
            flush   = ($urandom_range(0, 39) == 0);
            stall   = ($urandom_range(0, 3) == 0);
            issue_a = busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            issue_b = $urandom_range(0, 1) == 1;
            if ((DEPTH - mq.size()) >= 2) set_push(2'($urandom_range(0, 3)));
            else push_valid = 2'b00;
            run_cycle("rand");
        end
        idle();

        // Asynchronous reset between clock edges.
        set_push(2'b11);
        run_cycle("pre_areset");
        idle();
        #2;
        rst = 1;
        #1;
        chk("areset_count", word_t'(count), '0);
        chk("areset_ready", word_t'(push_ready), word_t'(1));
        chk("areset_va", word_t'(out_valid_a), '0);
        chk("areset_vb", word_t'(out_valid_b), '0);
        chk("areset_da", word_t'(out_data_a), '0);
        mq.delete();
        @(posedge clk); #1;
        rst = 0;
        run_cycle("post_areset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_issue_queue.md
# inst_issue_queue

Instruction issue queue between fetch and the dual-issue decode stage. Fetch pushes 0–2 instructions per cycle. The queue presents the two oldest entries to decoders A and B. Each cycle it retires 0, 1 or 2 entries according to the issue decision of the superscalar pairing logic (pipe-A issue, plus pipe-B issue when `inst2_taken`).

## Interface
Parameters:
- `DEPTH`, default 8: number of entries; power of two, at least 4.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset; **asynchronous, active-high**.
- `flush`  in  1  discard all entries (branch mispredict, exception, ERET).
- `stall`  in  1  decode stalled; no entries retire this cycle.
- `push_valid`  in  2  per-slot valid of the fetch pair; bit 0 is the older slot.
- `push_data`  in  `IssueEntry_t`[2]  fetched entries.
- `push_ready`  out  1  at least 2 free entries; fetch may push only while this is high.
- `out_valid_a`, `out_valid_b`  out  1 each  head / head+1 entry present.
- `out_data_a`, `out_data_b`  out  `IssueEntry_t` each  head / head+1 entry.
- `issue_a`  in  1  pipe A consumed `out_data_a`.
- `issue_b`  in  1  pipe B consumed `out_data_b` (the `inst2_taken` result); meaningful only with `issue_a`.
- `count`  out  `$clog2(DEPTH)+1`  current occupancy.

## Operation
- Storage is `DEPTH` registers of `IssueEntry_t`.
- Read pointer, write pointer and count are registers. Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
- Push compaction:
  - Valid slots are written in order, slot 0 then slot 1, starting at the write pointer.
  - `2'b01` and `2'b10` each write one entry; `2'b11` writes two; `2'b00` writes none.
- Push while `push_ready`=0 is a protocol violation. The push is dropped and no state changes. A simulation assertion fires.
- Retire count (`pop_n`):
  - `pop_n` = 0 if `stall` or `!issue_a`.
  - Otherwise `pop_n` = 1 + `issue_b`.
  - `pop_n` is clamped to `count`; `issue_b` with `out_valid_b`=0 retires only one entry.
- Next state:
  - `count_next` = `count` + `push_n` − `pop_n`.
  - The read pointer advances by `pop_n`; the write pointer advances by `push_n`.
- `flush` has priority over everything else. Next cycle count=0 and both pointers=0. Pushes and pops in the flush cycle are discarded.
- `push_ready` = (`DEPTH` − `count`) ≥ 2, computed from registered `count` only. There is no combinational path from `issue_*`/`stall` to `push_ready`.
- Outputs:
  - `out_valid_a` = `count` ≥ 1.
  - `out_valid_b` = `count` ≥ 2.
  - Data is read combinationally from storage at `rptr` and `rptr+1` (mod `DEPTH`).
  - When the matching valid is 0, data is don't-care, but the model drives zero.

## Timing
- Reset values: `count`=0, pointers=0, `out_valid_a`=`out_valid_b`=0, `push_ready`=1, `out_data_*`=0. Storage is not reset.
- Push latency: an entry pushed in cycle t is visible on `out_data_*` in cycle t+1 (without bypass).
- Pop: entries retired in cycle t are replaced by the next-oldest entries in cycle t+1.
- Simultaneous push and pop at any occupancy is legal. A full queue (`count`=`DEPTH`) with `pop_n`=2 still has `push_ready`=0 that cycle.
- Reset asserted mid-operation clears state immediately (asynchronous). Outputs reach reset values without waiting for a clock edge.

## Configuration
- `ISSUE_QUEUE_BYPASS_EN` defined:
  - When `count`=0, pushed entries drive `out_data_a`/`out_data_b` and `out_valid_*` combinationally in the same cycle.
  - Bypassed entries that are issued that cycle are not written into storage; those not issued are written normally.
  - `flush` suppresses the bypass.
- Undefined: one-cycle minimum latency, with no combinational path from `push_*` to the outputs.

## Structure
- `IssueEntry_t` belongs in `cpu_defs.svh` (alongside `PipelineData_t`): `Address_t pc`, `Inst_t inst`, `Bit_t iaddr_err`, `Bit_t itlb_miss`, `Bit_t itlb_invalid`.
- Also in `cpu_defs.svh`: `` `ISSUE_QUEUE_DEPTH `` (default 8).
- No sub-module: pointer/count logic and storage stay in one module.

## Test plan
- Reset, then push `2'b11` (pc `0x1000`, `0x1004`); next cycle `out_valid_a`=`out_valid_b`=1 with those pcs, `count`=2.
- `count`=3, `issue_a`=1, `issue_b`=1 → next cycle `count`=1 and `out_data_a` holds the third entry; then `issue_a`=1 with `issue_b`=1 while `out_valid_b`=0 → retires exactly one, `count`=0.
- Fill to `DEPTH`−1 → `push_ready`=0; pop 1 → `push_ready`=1 next cycle; pointers wrap with order preserved across 3×`DEPTH` entries.
- Push `2'b10` (pc `0x2004` in slot 1) into an empty queue → next cycle `out_data_a.pc`=`0x2004`, `count`=1.
- `flush` together with push `2'b11` and `issue_a`=1 at `count`=5 → next cycle `count`=0, outputs invalid.
- With `ISSUE_QUEUE_BYPASS_EN`: empty queue, push `2'b11`, `issue_a`=1, `issue_b`=0 → same cycle `out_valid_a`=1; next cycle `count`=1 holding the slot-1 entry.
